// File: rtl/cmd_pkg.sv
// Shared constants for the UART command register file: command bytes,
// response status codes, the drop-counter address and FSM/decode encodings.
package cmd_pkg;

    localparam logic [7:0] CMD_PING  = 8'h70;
    localparam logic [7:0] CMD_READ  = 8'h72;
    localparam logic [7:0] CMD_WRITE = 8'h77;
    localparam logic [7:0] CMD_SET   = 8'h73;
    localparam logic [7:0] CMD_CLR   = 8'h63;

    localparam logic [7:0] ST_OK       = 8'h00;
    localparam logic [7:0] ST_BAD_ADDR = 8'hE1;
    localparam logic [7:0] ST_RO_WRITE = 8'hE2;
    localparam logic [7:0] ST_BAD_CMD  = 8'hE3;

    localparam logic [7:0] ADDR_DROP = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CLS_RW   = 2'd0,
        CLS_RO   = 2'd1,
        CLS_DROP = 2'd2,
        CLS_BAD  = 2'd3
    } addr_class_t;

endpackage

// File: rtl/cmd_regfile_decode.sv
// Combinational address/command classifier: yields the address class, the
// word index within that class, the response status and the write permission.
module cmd_regfile_decode
    import cmd_pkg::*;
#(
    parameter int P_NUM_RW = 16,
    parameter int P_NUM_RO = 4
) (
    input  logic [7:0]  cmd,
    input  logic [7:0]  addr,
    output addr_class_t addr_cls,
    output logic [7:0]  word_idx,
    output logic [7:0]  status,
    output logic        wr_en
);

    localparam logic [8:0] RW_END = 9'(P_NUM_RW);
    localparam logic [8:0] RO_END = 9'(P_NUM_RW + P_NUM_RO);

    logic [8:0] addr_ext;
    logic [8:0] ro_off;
    logic       is_read;
    logic       is_mod;

    assign addr_ext = {1'b0, addr};
    assign ro_off   = addr_ext - RW_END;
    assign is_read  = (cmd == CMD_READ);
    assign is_mod   = (cmd == CMD_WRITE) || (cmd == CMD_SET) || (cmd == CMD_CLR);

    always_comb begin
        addr_cls = CLS_BAD;
        word_idx = 8'd0;
        if (addr == ADDR_DROP) begin
            addr_cls = CLS_DROP;
        end else if (addr_ext < RW_END) begin
            addr_cls = CLS_RW;
            word_idx = addr;
        end else if (addr_ext < RO_END) begin
            addr_cls = CLS_RO;
            word_idx = ro_off[7:0];
        end
    end

    // Unknown commands report E3 regardless of address validity.
    always_comb begin
        status = ST_OK;
        wr_en  = 1'b0;
        if (is_read) begin
            status = (addr_cls == CLS_BAD) ? ST_BAD_ADDR : ST_OK;
        end else if (is_mod) begin
            case (addr_cls)
                CLS_RW: begin
                    status = ST_OK;
                    wr_en  = 1'b1;
                end
                CLS_BAD: status = ST_BAD_ADDR;
                default: status = ST_RO_WRITE;
            endcase
        end else if (cmd != CMD_PING) begin
            status = ST_BAD_CMD;
        end
    end

endmodule

// File: rtl/cmd_regfile.sv
// Command-driven register file: RW registers, RO status words and a drop
// counter, answered with a registered status-tagged 64-bit response.
module cmd_regfile
    import cmd_pkg::*;
#(
    parameter int                  P_DATA_W  = 8,
    parameter int                  P_NUM_RW  = 16,
    parameter int                  P_NUM_RO  = 4,
    parameter logic [P_DATA_W-1:0] P_RST_VAL = '0
) (
    input  logic                                              i_clk,
    input  logic                                              i_rst,
    input  logic [7:0]                                        i_cmd,
    input  logic [63:0]                                       i_cmd_data,
    input  logic                                              i_cmd_new,
    output logic [63:0]                                       o_resp_data,
    output logic                                              o_resp_ready,
    input  logic                                              i_resp_ack,
    output logic                                              o_busy,
    output logic [P_NUM_RW*P_DATA_W-1:0]                      o_regs,
    output logic [P_NUM_RW-1:0]                               o_wr_stb,
    input  logic [((P_NUM_RO > 0) ? P_NUM_RO : 1)*P_DATA_W-1:0] i_status
);

    localparam int RO_SLOTS = (P_NUM_RO > 0) ? P_NUM_RO : 1;
    localparam int PAD_W    = 56 - P_DATA_W;

    state_t                state_q, state_d;
    logic [7:0]            cmd_q;
    logic [63:0]           data_q;
    logic [P_DATA_W-1:0]   regs_q [P_NUM_RW];
    logic [P_NUM_RW-1:0]   wr_stb_q;
    logic [63:0]           resp_q;
    logic [7:0]            drop_q;

    addr_class_t           addr_cls;
    logic [7:0]            word_idx;
    logic [7:0]            status;
    logic                  wr_en;

    logic [P_DATA_W-1:0]   opnd;
    logic [P_DATA_W-1:0]   rw_val;
    logic [P_DATA_W-1:0]   ro_val;
    logic [P_DATA_W-1:0]   new_val;
    logic [55:0]           value;
    logic [63:0]           resp_next;

    assign opnd = data_q[8 +: P_DATA_W];

    cmd_regfile_decode #(
        .P_NUM_RW (P_NUM_RW),
        .P_NUM_RO (P_NUM_RO)
    ) u_decode (
        .cmd      (cmd_q),
        .addr     (data_q[7:0]),
        .addr_cls (addr_cls),
        .word_idx (word_idx),
        .status   (status),
        .wr_en    (wr_en)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        o_busy       = 1'b1;
        o_resp_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_cmd_new) state_d = S_EXEC;
            end
            S_EXEC: state_d = S_RESP;
            S_RESP: begin
                o_resp_ready = 1'b1;
                if (i_resp_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rw_val = '0;
        for (int k = 0; k < P_NUM_RW; k++) begin
            if (word_idx == 8'(k)) rw_val = regs_q[k];
        end
        ro_val = '0;
        for (int k = 0; k < RO_SLOTS; k++) begin
            if (word_idx == 8'(k)) ro_val = i_status[k*P_DATA_W +: P_DATA_W];
        end
    end

    always_comb begin
        case (cmd_q)
            CMD_WRITE: new_val = opnd;
            CMD_SET:   new_val = rw_val | opnd;
            CMD_CLR:   new_val = rw_val & ~opnd;
            default:   new_val = rw_val;
        endcase
    end

    // Only OK and read-only-write responses carry a value; other errors report zero.
    always_comb begin
        value = '0;
        if ((status == ST_OK) || (status == ST_RO_WRITE)) begin
            case (addr_cls)
                CLS_RW:   value = {{PAD_W{1'b0}}, (wr_en ? new_val : rw_val)};
                CLS_RO:   value = {{PAD_W{1'b0}}, ro_val};
                CLS_DROP: value = {48'd0, drop_q};
                default:  value = '0;
            endcase
        end
        resp_next = (cmd_q == CMD_PING) ? data_q : {status, value};
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            cmd_q    <= '0;
            data_q   <= '0;
            resp_q   <= '0;
            wr_stb_q <= '0;
            drop_q   <= '0;
            for (int k = 0; k < P_NUM_RW; k++) regs_q[k] <= P_RST_VAL;
        end else begin
            wr_stb_q <= '0;
            if ((state_q == S_IDLE) && i_cmd_new) begin
                cmd_q  <= i_cmd;
                data_q <= i_cmd_data;
            end
            if (state_q == S_EXEC) begin
                resp_q <= resp_next;
                if (wr_en) begin
                    for (int k = 0; k < P_NUM_RW; k++) begin
                        if (word_idx == 8'(k)) begin
                            regs_q[k]   <= new_val;
                            wr_stb_q[k] <= 1'b1;
                        end
                    end
                end
            end
            if ((state_q != S_IDLE) && i_cmd_new && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    generate
        for (genvar g = 0; g < P_NUM_RW; g++) begin : g_regs
            assign o_regs[g*P_DATA_W +: P_DATA_W] = regs_q[g];
        end
    endgenerate

    assign o_resp_data = resp_q;
    assign o_wr_stb    = wr_stb_q;

endmodule
